axis_idle_rle: RTL and testbench
================================

# axis_idle_rle

Downstream stage of the TLAST-framed processor output: consumes the flagged AXI-Stream (MSB of `tdata` = "processor produced output this cycle") and run-length-compresses consecutive idle beats (flag = 0) into a single count beat, cutting host-link bandwidth when the network is quiet. Active beats (flag = 1) pass unchanged; packet framing (`tlast`) is preserved. Sits between the processor's TLAST wrapper and the DMA/UART sink.

## Interface
- `DATA_WIDTH`, 32, stream `tdata` width in bits; bit `DATA_WIDTH-1` is the valid flag.
- `CNT_WIDTH`, 16, idle-run counter width; legal range 2..`DATA_WIDTH-1`; `CNT_MAX` = 2^`CNT_WIDTH`-1.
- `clk`  in  1  sole clock; all logic rising-edge.
- `arst`  in  1  reset, asynchronous, active-high.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tready`  out  1  input beat accepted when high with `s_axis_tvalid`.
- `s_axis_tdata`  in  `DATA_WIDTH`  flag in MSB, payload below.
- `s_axis_tlast`  in  1  end of packet.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tdata`  out  `DATA_WIDTH`  passed active beat, or `{1'b0, zeros, count[CNT_WIDTH-1:0]}` run beat.
- `m_axis_tlast`  out  1  end of packet.
- `m_axis_tkeep`  out  `DATA_WIDTH/8`  constant all-ones.

## Operation
- Single output register OREG (`m_axis_*`). `ofree` = `!m_axis_tvalid || m_axis_tready`.
- State machine: NORUN (no idle run pending), RUN (run pending, `cnt` ≥ 1, not yet emitted). Registers: `state`, `cnt[CNT_WIDTH-1:0]`.
- `s_axis_tready` = `ofree && !arst && !(state==RUN && s_axis_tvalid && s_axis_tdata[MSB])`.
- Accepted active beat, NORUN: OREG ← input `tdata`/`tlast` unchanged.
- Active beat presented in RUN with `ofree`: OREG ← run beat (count `cnt`, `tlast`=0); state → NORUN; input not accepted that cycle; accepted on a following cycle per the NORUN rule.
- Accepted idle beat: `n` = (state==NORUN) ? 1 : `cnt`+1.
  - If input `tlast`=1 or `n`==`CNT_MAX`: OREG ← run beat with count `n`, `tlast` = input `tlast`; state → NORUN; `cnt` ← 0.
  - Else: `cnt` ← `n`, state → RUN, OREG unchanged except normal drain.
- Idle-beat payload bits are discarded; only the count is emitted.
- A pending run is emitted only by an active beat, `tlast`, or saturation; upstream guarantees every packet ends with `tlast`, so no timeout flush.
- Sum of counts in emitted run beats equals number of idle beats accepted; order of all beats preserved; no beat duplicated or dropped under any backpressure.

## Timing
- Reset (asserted): `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `s_axis_tready`=0, state NORUN, `cnt`=0. Reset mid-run discards the pending run and any unaccepted OREG beat.
- Active beat in NORUN: on `m_axis` the cycle after acceptance (latency 1); full throughput, one beat per cycle, when `m_axis_tready`=1.
- Active beat after a run: run beat appears 1 cycle after the flush cycle; active beat 1 cycle later; `s_axis_tready` low exactly one cycle when `m_axis_tready`=1.
- Idle beats: no output until terminating event; run beat appears cycle after terminating idle beat accepted.
- OREG holds `tdata`/`tlast` stable while `m_axis_tvalid && !m_axis_tready`.
- Simultaneous saturation and `tlast` on one idle beat: single run beat, count `CNT_MAX`, `tlast`=1.

## Test plan
- Active only (`DATA_WIDTH`=32): 0x80000005, 0x80000007+tlast, `m_axis_tready`=1 -> same two beats, tlast on second, 1-cycle latency, `s_axis_tready` constantly 1.
- 5 idle beats then active 0x800000AA+tlast -> 0x00000005 tlast=0, then 0x800000AA tlast=1; `s_axis_tready` low one cycle.
- 3 idle beats, third with tlast -> single beat 0x00000003 tlast=1; nothing else emitted.
- `CNT_WIDTH`=4: 21 idle beats, last with tlast -> 0x0000000F tlast=0, then 0x00000006 tlast=1.
- Random mixed stream (1000 beats) with random `m_axis_tready` (50%) and `s_axis_tvalid` gaps -> scoreboard: active beats in order, run counts sum to idle-beat count per packet, tlast count equal, data stable while stalled.
- Assert `arst` after 3 idle beats (no tlast), release, send active 0x80000001+tlast -> only 0x80000001 tlast=1 emitted; all outputs 0 during reset.

Source files
------------

// File: rtl/axis_idle_rle.sv
`default_nettype none
// ============================================================================
//  Module      : axis_idle_rle
//  Description : Run-length compressor for a flagged AXI-Stream. The MSB of
//                tdata marks an active beat; consecutive idle beats (MSB = 0)
//                collapse into one run beat that carries the idle count in
//                its low CNT_WIDTH bits. Active beats and tlast framing pass
//                through unchanged.
//
//  Ports
//    clk            in   sole clock, rising edge
//    arst           in   asynchronous active-high reset
//    s_axis_tvalid  in   input beat valid
//    s_axis_tready  out  input beat accepted when high with s_axis_tvalid
//    s_axis_tdata   in   [DATA_WIDTH-1] activity flag, payload below
//    s_axis_tlast   in   end of packet
//    m_axis_tvalid  out  output beat valid
//    m_axis_tready  in   downstream ready
//    m_axis_tdata   out  active beat, or {0, zeros, count} run beat
//    m_axis_tlast   out  end of packet
//    m_axis_tkeep   out  constant all-ones
//
//  Revision    : 1.0  initial release
// ============================================================================
module axis_idle_rle #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep
);

    localparam int                   c_MSB     = DATA_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    localparam logic [0:0] c_ST_NORUN = 1'b0;   // no idle run pending
    localparam logic [0:0] c_ST_RUN   = 1'b1;   // run pending, count >= 1

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_m_tvalid;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tlast;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    logic                  w_ofree;
    logic                  w_in_active;
    logic                  w_accept;
    logic                  w_flush;
    logic                  w_idle_acc;
    logic                  w_idle_term;
    logic [CNT_WIDTH-1:0]  w_n;

    logic [0:0]            w_state_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic                  w_s_tready;
    logic                  w_oreg_load;
    logic [DATA_WIDTH-1:0] w_oreg_tdata;
    logic                  w_oreg_tlast;

    // Run beat: flag clear, count in the low bits, everything else zero.
    function automatic logic [DATA_WIDTH-1:0] f_run_beat(input logic [CNT_WIDTH-1:0] count);
        logic [DATA_WIDTH-1:0] beat;
        beat                 = '0;
        beat[CNT_WIDTH-1:0]  = count;
        return beat;
    endfunction

    assign w_ofree     = !r_m_tvalid || m_axis_tready;
    assign w_in_active = s_axis_tvalid && s_axis_tdata[c_MSB];

    // An active beat arriving while a run is pending first forces the run
    // out; the active beat itself is held off for that one cycle so the
    // run beat lands in the output register ahead of it.
    assign w_flush     = (r_state == c_ST_RUN) && w_in_active && w_ofree;

    assign w_accept    = s_axis_tvalid && w_s_tready;
    assign w_idle_acc  = w_accept && !s_axis_tdata[c_MSB];

    // Length of the run including the idle beat currently being accepted.
    assign w_n         = (r_state == c_ST_NORUN) ? c_CNT_ONE : (r_cnt + c_CNT_ONE);

    // An idle beat closes its run on end-of-packet or when the counter
    // would otherwise overflow.
    assign w_idle_term = w_idle_acc && (s_axis_tlast || (w_n == c_CNT_MAX));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= c_ST_NORUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_flush) begin
            w_state_nxt = c_ST_NORUN;
            w_cnt_nxt   = '0;
        end else if (w_idle_acc) begin
            if (w_idle_term) begin
                w_state_nxt = c_ST_NORUN;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = c_ST_RUN;
                w_cnt_nxt   = w_n;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic: input ready and output-register load value
    // ------------------------------------------------------------------
    always_comb begin
        w_s_tready   = w_ofree && !arst &&
                       !((r_state == c_ST_RUN) && w_in_active);
        w_oreg_load  = 1'b0;
        w_oreg_tdata = r_m_tdata;
        w_oreg_tlast = r_m_tlast;
        if (w_flush) begin
            w_oreg_load  = 1'b1;
            w_oreg_tdata = f_run_beat(r_cnt);
            w_oreg_tlast = 1'b0;
        end else if (w_accept && s_axis_tdata[c_MSB]) begin
            w_oreg_load  = 1'b1;
            w_oreg_tdata = s_axis_tdata;
            w_oreg_tlast = s_axis_tlast;
        end else if (w_idle_term) begin
            w_oreg_load  = 1'b1;
            w_oreg_tdata = f_run_beat(w_n);
            w_oreg_tlast = s_axis_tlast;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_oreg_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_oreg_tdata;
            r_m_tlast  <= w_oreg_tlast;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign s_axis_tready = w_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tkeep  = '1;

endmodule
`default_nettype wire

// File: tb/tb_axis_idle_rle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_idle_rle
//  Description : Self-checking bench for axis_idle_rle. Expected output beats
//                are queued when stimulus is issued; a monitor pops and
//                compares every output handshake and checks output stability
//                while stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axis_idle_rle;

    localparam int c_DW      = 32;
    localparam int c_CW      = 4;
    localparam int c_CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              arst;
    logic              s_tvalid;
    logic              s_tready;
    logic [c_DW-1:0]   s_tdata;
    logic              s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [c_DW-1:0]   m_tdata;
    logic              m_tlast;
    logic [c_DW/8-1:0] m_tkeep;

    always #5 clk = ~clk;

    axis_idle_rle #(.DATA_WIDTH(c_DW), .CNT_WIDTH(c_CW)) dut (
        .clk           (clk),
        .arst          (arst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tkeep  (m_tkeep)
    );

    typedef struct packed {
        logic [c_DW-1:0] d;
        logic            l;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic  rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [c_DW-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        exp_q.push_back(b);
    endtask

    // ------------------------------------------------------------------
    // Downstream ready driver
    // ------------------------------------------------------------------
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares each handshake against the queue head
    // ------------------------------------------------------------------
    beat_t           mon_e;
    logic            hold_v = 1'b0;
    logic [c_DW-1:0] hold_d;
    logic            hold_l;

    always @(negedge clk) begin
        if (arst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 32'(m_tvalid), 32'd1);
                check("stall_data",  m_tdata, hold_d);
                check("stall_last",  32'(m_tlast), 32'(hold_l));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat actual=0x%08h last=%0d expected=none",
                             m_tdata, m_tlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", m_tdata, mon_e.d);
                    check("out_last", 32'(m_tlast), 32'(mon_e.l));
                end
            end
            hold_v = m_tvalid && !m_tready;
            hold_d = m_tdata;
            hold_l = m_tlast;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called just after a rising edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [c_DW-1:0] d, input logic l, output int stalls);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        stalls   = 0;
        @(negedge clk);
        while (!s_tready && stalls < 500) begin
            stalls++;
            @(negedge clk);
        end
        if (!s_tready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout actual=stalled expected=accept data=0x%08h", d);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain;
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int st;
        int pend;
        logic            flag;
        logic            last;
        logic [c_DW-1:0] d;

        arst     = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        s_tvalid = 1'b1;
        s_tdata  = 32'h8000_0009;
        @(negedge clk);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata",  m_tdata, 32'd0);
        check("rst_m_tlast",  32'(m_tlast), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("tkeep",        32'(m_tkeep), 32'hF);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        arst     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Active beats only: pass-through, latency 1, never stalled.
        push(32'h8000_0005, 1'b0);
        push(32'h8000_0007, 1'b1);
        send(32'h8000_0005, 1'b0, st);
        check("t1_stall0", 32'(st), 32'd0);
        check("t1_lat_valid", 32'(m_tvalid), 32'd1);
        check("t1_lat_data",  m_tdata, 32'h8000_0005);
        send(32'h8000_0007, 1'b1, st);
        check("t1_stall1", 32'(st), 32'd0);
        check("t1_lat_data2", m_tdata, 32'h8000_0007);
        drain();

        // Five idle beats then an active beat with tlast.
        push(32'h0000_0005, 1'b0);
        push(32'h8000_00AA, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(32'h0000_1230 + 32'(i), 1'b0, st);
            check("t2_idle_stall", 32'(st), 32'd0);
        end
        send(32'h8000_00AA, 1'b1, st);
        check("t2_flush_stall", 32'(st), 32'd1);
        drain();

        // Three idle beats, the third ends the packet.
        push(32'h0000_0003, 1'b1);
        for (int i = 0; i < 3; i++) send(32'h7FFF_FFFF, (i == 2), st);
        drain();

        // Saturation: 21 idle beats with a 4-bit counter.
        push(32'h0000_000F, 1'b0);
        push(32'h0000_0006, 1'b1);
        for (int i = 0; i < 21; i++) send(32'h0000_0000, (i == 20), st);
        drain();

        // Saturation coinciding with tlast.
        push(32'h0000_000F, 1'b1);
        for (int i = 0; i < 15; i++) send(32'h0000_0055, (i == 14), st);
        drain();

        // Random mixed stream under random backpressure and input gaps.
        rand_ready = 1'b1;
        pend = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            flag = ($urandom_range(0, 99) < 45);
            last = (i == 999) || ($urandom_range(0, 9) == 0);
            d    = {flag, 31'($urandom())};
            if (flag) begin
                if (pend > 0) push(32'(pend), 1'b0);
                pend = 0;
                push(d, last);
            end else begin
                pend++;
                if (last || pend == c_CNT_MAX) begin
                    push(32'(pend), last);
                    pend = 0;
                end
            end
            send(d, last, st);
        end
        rand_ready = 1'b0;
        drain();

        // Reset in the middle of a pending run discards it.
        for (int i = 0; i < 3; i++) send(32'h0000_0000, 1'b0, st);
        arst     = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'h8000_0001;
        @(negedge clk);
        check("rst2_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst2_m_tdata",  m_tdata, 32'd0);
        check("rst2_m_tlast",  32'(m_tlast), 32'd0);
        check("rst2_s_tready", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        arst     = 1'b0;
        @(posedge clk);
        #1;
        push(32'h8000_0001, 1'b1);
        send(32'h8000_0001, 1'b1, st);
        check("rst2_stall", 32'(st), 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
